// File: rtl/i2c_regbank_pkg.sv
// ============================================================================
// Module : i2c_regbank_pkg
// Brief  : Shared state encodings and constants for the I2C register bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package i2c_regbank_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    localparam int unsigned WR_COUNT_MAX = 255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'(WR_COUNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_regbank_mem.sv
// ============================================================================
// Module : i2c_regbank_mem
// Brief  : Single write port, two registered read ports with write-first bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_regbank_mem
    import i2c_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    input  logic                  b_en_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    output logic [DATA_WIDTH-1:0] b_rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= (we_i && (waddr_i == a_addr_i)) ? wdata_i : mem_q[a_addr_i];
            if (b_en_i) begin
                b_rdata_q <= (we_i && (waddr_i == b_addr_i)) ? wdata_i : mem_q[b_addr_i];
            end
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

`default_nettype wire

// File: rtl/i2c_regbank_arbiter.sv
// ============================================================================
// Module : i2c_regbank_arbiter
// Brief  : Shares the I2C register bank between the I2C slave and a host port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_regbank_arbiter
    import i2c_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter bit LOCK_ON_BUSY = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2c_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] i2c_addr_i,
    input  logic [DATA_WIDTH-1:0] i2c_wdata_i,
    output logic [DATA_WIDTH-1:0] i2c_rdata_o,
    input  logic                  i2c_busy_i,
    input  logic                  i2c_done_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    output logic                  host_ack_o,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    output logic                  init_done_o,
    output logic                  i2c_wr_irq_o,
    output logic [7:0]            i2c_wr_count_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  init_done_q, init_done_d;
    logic                  h_we_q, h_we_d;
    logic [ADDR_WIDTH-1:0] h_addr_q, h_addr_d;
    logic [DATA_WIDTH-1:0] h_wdata_q, h_wdata_d;
    logic                  busy_q, done_q;
    logic [7:0]            run_cnt_q, run_cnt_d;
    logic [7:0]            wr_count_q, wr_count_d;
    logic                  irq_q, irq_d;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_b_en;
    logic                  w_i2c_acc;
    logic [7:0]            w_run_base;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        h_we_d      = h_we_q;
        h_addr_d    = h_addr_q;
        h_wdata_d   = h_wdata_q;
        w_mem_we    = i2c_wr_en_i;
        w_mem_waddr = i2c_addr_i;
        w_mem_wdata = i2c_wdata_i;
        w_b_en      = 1'b0;
        host_ack_o  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = ptr_q;
                w_mem_wdata = '0;
                ptr_d       = ptr_q + 1'b1;
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (host_req_i && !i2c_wr_en_i && (!LOCK_ON_BUSY || !i2c_busy_i)) begin
                    h_we_d    = host_we_i;
                    h_addr_d  = host_addr_i;
                    h_wdata_d = host_wdata_i;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!h_we_q) begin
                    w_b_en  = 1'b1;
                    state_d = ST_ACK;
                end else if (!i2c_wr_en_i) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = h_addr_q;
                    w_mem_wdata = h_wdata_q;
                    state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                host_ack_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Count only I2C writes that actually land; the done-edge write is included.
    assign w_i2c_acc  = i2c_wr_en_i && (state_q != ST_CLEAR);
    assign w_run_base = (i2c_busy_i && !busy_q) ? 8'd0 : run_cnt_q;

    always_comb begin
        run_cnt_d  = w_i2c_acc ? sat_inc(w_run_base) : w_run_base;
        wr_count_d = wr_count_q;
        irq_d      = 1'b0;
        if (i2c_done_i && !done_q) begin
            wr_count_d = run_cnt_d;
            irq_d      = (run_cnt_d != 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            h_we_q      <= 1'b0;
            h_addr_q    <= '0;
            h_wdata_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            run_cnt_q   <= 8'd0;
            wr_count_q  <= 8'd0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            h_we_q      <= h_we_d;
            h_addr_q    <= h_addr_d;
            h_wdata_q   <= h_wdata_d;
            busy_q      <= i2c_busy_i;
            done_q      <= i2c_done_i;
            run_cnt_q   <= run_cnt_d;
            wr_count_q  <= wr_count_d;
            irq_q       <= irq_d;
        end
    end

    i2c_regbank_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .we_i      (w_mem_we),
        .waddr_i   (w_mem_waddr),
        .wdata_i   (w_mem_wdata),
        .a_addr_i  (i2c_addr_i),
        .a_rdata_o (i2c_rdata_o),
        .b_en_i    (w_b_en),
        .b_addr_i  (h_addr_q),
        .b_rdata_o (host_rdata_o)
    );

    assign init_done_o    = init_done_q;
    assign i2c_wr_irq_o   = irq_q;
    assign i2c_wr_count_o = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_regbank_arbiter.sv
// ============================================================================
// Module : tb_i2c_regbank_arbiter
// Brief  : Directed self-checking bench; dut1 locks on busy, dut0 does not.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_regbank_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i2c_wr_en = 1'b0;
    logic [7:0]  i2c_addr = 8'h00;
    logic [15:0] i2c_wdata = 16'h0000;
    logic        i2c_busy = 1'b0;
    logic        i2c_done = 1'b0;

    logic        h1_req = 1'b0, h1_we = 1'b0;
    logic [7:0]  h1_addr = 8'h00;
    logic [15:0] h1_wdata = 16'h0000;
    logic        h0_req = 1'b0, h0_we = 1'b0;
    logic [7:0]  h0_addr = 8'h00;
    logic [15:0] h0_wdata = 16'h0000;

    logic [15:0] i2c_rdata1, h1_rdata, i2c_rdata0, h0_rdata;
    logic        h1_ack, init_done1, irq1, h0_ack, init_done0, irq0;
    logic [7:0]  cnt1, cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2c_regbank_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LOCK_ON_BUSY(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .i2c_wr_en_i(i2c_wr_en), .i2c_addr_i(i2c_addr), .i2c_wdata_i(i2c_wdata),
        .i2c_rdata_o(i2c_rdata1), .i2c_busy_i(i2c_busy), .i2c_done_i(i2c_done),
        .host_req_i(h1_req), .host_we_i(h1_we), .host_addr_i(h1_addr), .host_wdata_i(h1_wdata),
        .host_ack_o(h1_ack), .host_rdata_o(h1_rdata), .init_done_o(init_done1),
        .i2c_wr_irq_o(irq1), .i2c_wr_count_o(cnt1)
    );

    i2c_regbank_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LOCK_ON_BUSY(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .i2c_wr_en_i(i2c_wr_en), .i2c_addr_i(i2c_addr), .i2c_wdata_i(i2c_wdata),
        .i2c_rdata_o(i2c_rdata0), .i2c_busy_i(i2c_busy), .i2c_done_i(i2c_done),
        .host_req_i(h0_req), .host_we_i(h0_we), .host_addr_i(h0_addr), .host_wdata_i(h0_wdata),
        .host_ack_o(h0_ack), .host_rdata_o(h0_rdata), .init_done_o(init_done0),
        .i2c_wr_irq_o(irq0), .i2c_wr_count_o(cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded host transaction; cyc = edges from request to visible ack (50 = timeout).
    task automatic host_txn(input bit sel0, input bit we, input logic [7:0] a,
                            input logic [15:0] d, output logic [15:0] rd, output int cyc);
        if (sel0) begin h0_req = 1'b1; h0_we = we; h0_addr = a; h0_wdata = d; end
        else      begin h1_req = 1'b1; h1_we = we; h1_addr = a; h1_wdata = d; end
        cyc = 0;
        rd  = 16'hxxxx;
        while (cyc < 50) begin
            tick();
            cyc++;
            if (sel0 ? h0_ack : h1_ack) begin
                rd = sel0 ? h0_rdata : h1_rdata;
                break;
            end
        end
        h0_req = 1'b0;
        h1_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        int cyc, n;
        reset = 1'b0;
        repeat (3) tick();
        n_checks++; if (init_done1 !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b expected 0", init_done1); end
        n_checks++; if (h1_ack !== 1'b0) begin n_fail++; $display("FAIL rst_host_ack: got %b expected 0", h1_ack); end
        n_checks++; if (h1_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_host_rdata: got %h expected 0000", h1_rdata); end
        n_checks++; if (i2c_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL rst_i2c_rdata: got %h expected 0000", i2c_rdata1); end
        n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq1); end
        n_checks++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", cnt1); end
        reset = 1'b1;
        n = 0;
        while (!init_done1 && n < 300) begin tick(); n++; end
        n_checks++; if (n !== 256) begin n_fail++; $display("FAIL clear_cycles: got %0d expected 256", n); end
        n_checks++; if (init_done0 !== 1'b1) begin n_fail++; $display("FAIL clear_done_dut0: got %b expected 1", init_done0); end
        host_txn(1'b0, 1'b0, 8'h7F, 16'h0000, rd, cyc);
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL read_7f: got %h expected 0000", rd); end
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL read_7f_latency: got %0d expected 2", cyc); end
    endtask

    task automatic test_i2c_write();
        logic [15:0] rd;
        int cyc;
        i2c_addr = 8'h10; i2c_wdata = 16'h12AB; i2c_wr_en = 1'b1;
        tick();
        i2c_wr_en = 1'b0;
        n_checks++; if (i2c_rdata1 !== 16'h12AB) begin n_fail++; $display("FAIL i2c_bypass: got %h expected 12ab", i2c_rdata1); end
        tick();
        n_checks++; if (i2c_rdata1 !== 16'h12AB) begin n_fail++; $display("FAIL i2c_readback: got %h expected 12ab", i2c_rdata1); end
        i2c_addr = 8'h11;
        tick();
        n_checks++; if (i2c_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL i2c_read_11: got %h expected 0000", i2c_rdata1); end
        host_txn(1'b0, 1'b0, 8'h10, 16'h0000, rd, cyc);
        n_checks++; if (rd !== 16'h12AB) begin n_fail++; $display("FAIL host_read_10: got %h expected 12ab", rd); end
    endtask

    task automatic test_lock_on_busy();
        logic [15:0] rd;
        int cyc, n;
        bit acked;
        i2c_busy = 1'b1;
        tick();
        h1_req = 1'b1; h1_we = 1'b1; h1_addr = 8'h20; h1_wdata = 16'hBEEF;
        acked = 1'b0;
        repeat (6) begin tick(); if (h1_ack) acked = 1'b1; end
        n_checks++; if (acked !== 1'b0) begin n_fail++; $display("FAIL lock_no_ack: got %b expected 0", acked); end
        i2c_busy = 1'b0;
        n = 0;
        while (!h1_ack && n < 20) begin tick(); n++; end
        h1_req = 1'b0;
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL lock_ack_latency: got %0d expected 2", n); end
        host_txn(1'b0, 1'b0, 8'h20, 16'h0000, rd, cyc);
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL lock_readback: got %h expected beef", rd); end
    endtask

    task automatic test_stall();
        logic [15:0] rd;
        int cyc;
        i2c_busy = 1'b1; i2c_done = 1'b0;
        tick();
        h0_req = 1'b1; h0_we = 1'b1; h0_addr = 8'h30; h0_wdata = 16'hCAFE;
        tick();
        i2c_addr = 8'h30; i2c_wdata = 16'h1111; i2c_wr_en = 1'b1;
        tick();
        i2c_wr_en = 1'b0;
        n_checks++; if (h0_ack !== 1'b0) begin n_fail++; $display("FAIL stall_no_ack: got %b expected 0", h0_ack); end
        n_checks++; if (i2c_rdata0 !== 16'h1111) begin n_fail++; $display("FAIL stall_i2c_val: got %h expected 1111", i2c_rdata0); end
        tick();
        n_checks++; if (h0_ack !== 1'b1) begin n_fail++; $display("FAIL stall_ack: got %b expected 1", h0_ack); end
        n_checks++; if (i2c_rdata0 !== 16'hCAFE) begin n_fail++; $display("FAIL stall_host_wins: got %h expected cafe", i2c_rdata0); end
        h0_req = 1'b0;
        i2c_busy = 1'b0; i2c_done = 1'b1;
        tick();
        n_checks++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL stall_irq: got %b expected 1", irq0); end
        n_checks++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL stall_count: got %0d expected 1", cnt0); end
        tick();
        n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL stall_irq_pulse: got %b expected 0", irq0); end
        i2c_done = 1'b0;
        host_txn(1'b1, 1'b0, 8'h30, 16'h0000, rd, cyc);
        n_checks++; if (rd !== 16'hCAFE) begin n_fail++; $display("FAIL stall_readback: got %h expected cafe", rd); end
    endtask

    task automatic test_summary();
        i2c_busy = 1'b1; i2c_done = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            i2c_addr = 8'h40 + 8'(i); i2c_wdata = 16'hA000 + 16'(i); i2c_wr_en = 1'b1;
            tick();
            i2c_wr_en = 1'b0;
            tick();
        end
        i2c_addr = 8'h42; i2c_wdata = 16'hA002; i2c_wr_en = 1'b1; i2c_done = 1'b1;
        tick();
        i2c_wr_en = 1'b0;
        n_checks++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL sum_irq: got %b expected 1", irq1); end
        n_checks++; if (cnt1 !== 8'd3) begin n_fail++; $display("FAIL sum_count: got %0d expected 3", cnt1); end
        tick();
        n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL sum_irq_once: got %b expected 0", irq1); end
        i2c_busy = 1'b0; i2c_done = 1'b0;
        tick();
        i2c_busy = 1'b1;
        tick();
        i2c_addr = 8'h41;
        tick();
        n_checks++; if (i2c_rdata1 !== 16'hA001) begin n_fail++; $display("FAIL ro_read_41: got %h expected a001", i2c_rdata1); end
        i2c_busy = 1'b0; i2c_done = 1'b1;
        tick();
        n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL ro_irq: got %b expected 0", irq1); end
        n_checks++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL ro_count: got %0d expected 0", cnt1); end
        i2c_done = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        h1_req = 1'b1; h1_we = 1'b0; h1_addr = 8'h50;
        tick();
        i2c_addr = 8'h50; i2c_wdata = 16'h7777; i2c_wr_en = 1'b1;
        tick();
        i2c_wr_en = 1'b0;
        n_checks++; if (h1_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %b expected 1", h1_ack); end
        n_checks++; if (h1_rdata !== 16'h7777) begin n_fail++; $display("FAIL b2b_read_bypass: got %h expected 7777", h1_rdata); end
        tick();
        n_checks++; if (h1_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_gap: got %b expected 0", h1_ack); end
        tick();
        tick();
        n_checks++; if (h1_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2: got %b expected 1", h1_ack); end
        n_checks++; if (h1_rdata !== 16'h7777) begin n_fail++; $display("FAIL b2b_read2: got %h expected 7777", h1_rdata); end
        h1_req = 1'b0;
        tick();
        n_checks++; if (h1_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_end: got %b expected 0", h1_ack); end
    endtask

    task automatic test_reset_mid_clear();
        int n, m;
        bit early_ack;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (8'h40) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        h1_req = 1'b1; h1_we = 1'b0; h1_addr = 8'h10;
        early_ack = 1'b0;
        n = 0;
        while (!init_done1 && n < 300) begin
            if (n == 10) begin i2c_addr = 8'h02; i2c_wdata = 16'hFFFF; i2c_wr_en = 1'b1; end
            else i2c_wr_en = 1'b0;
            tick();
            n++;
            if (h1_ack) early_ack = 1'b1;
        end
        i2c_wr_en = 1'b0;
        n_checks++; if (n !== 256) begin n_fail++; $display("FAIL reclear_cycles: got %0d expected 256", n); end
        n_checks++; if (early_ack !== 1'b0) begin n_fail++; $display("FAIL reclear_no_ack: got %b expected 0", early_ack); end
        m = 0;
        while (!h1_ack && m < 10) begin tick(); m++; end
        h1_req = 1'b0;
        n_checks++; if (m !== 2) begin n_fail++; $display("FAIL reclear_ack_latency: got %0d expected 2", m); end
        n_checks++; if (h1_rdata !== 16'h0000) begin n_fail++; $display("FAIL reclear_read_10: got %h expected 0000", h1_rdata); end
        i2c_addr = 8'h02;
        tick();
        n_checks++; if (i2c_rdata1 !== 16'h0000) begin n_fail++; $display("FAIL reclear_drop_write: got %h expected 0000", i2c_rdata1); end
    endtask

    initial begin
        test_reset();
        test_i2c_write();
        test_lock_on_busy();
        test_stall();
        test_summary();
        test_back_to_back();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
